// File: rtl/ram_copy_engine.sv
// Copies len consecutive words from src_addr to dst_addr inside a single-port RAM.
// Each word is a read, RD_LAT wait cycles, then a write. Define CHECKSUM_EN to add
// an XOR checksum output of all copied words.
//
// state  | meaning
// S_IDLE | ram idle, waiting for start
// S_RD   | read strobe at src_ptr
// S_WAIT | RD_LAT cycles for read data; word captured on the last one
// S_WR   | write strobe at dst_ptr, then advance pointers
// S_FIN  | copy finished, done pulses on the following cycle
module ram_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              m_cen,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int WCW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [ADDR_W:0]   remaining;
    logic [WCW-1:0]    wait_cnt;
    logic              accept, wait_last;
    logic              busy_nxt, done_nxt, m_cen_nxt, m_wen_nxt;
    logic [ADDR_W-1:0] m_addr_nxt;
    logic [DATA_W-1:0] m_din_nxt;

    assign accept    = (state == S_IDLE) && start;
    assign wait_last = (state == S_WAIT) && (wait_cnt == WCW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            m_cen  <= 1'b0;
            m_wen  <= 1'b0;
            m_addr <= '0;
            m_din  <= '0;
        end else begin
            state  <= state_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            m_cen  <= m_cen_nxt;
            m_wen  <= m_wen_nxt;
            m_addr <= m_addr_nxt;
            m_din  <= m_din_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (len != '0) ? S_RD : S_FIN;
            S_RD:    state_nxt = S_WAIT;
            S_WAIT:  if (wait_last) state_nxt = S_WR;
            S_WR:    state_nxt = (remaining == (ADDR_W+1)'(1)) ? S_FIN : S_RD;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with it after the edge;
    // m_din doubles as the captured read word and holds it through the write.
    always_comb begin
        busy_nxt   = state_nxt inside {S_RD, S_WAIT, S_WR};
        done_nxt   = (state == S_FIN);
        m_cen_nxt  = (state_nxt == S_RD) || (state_nxt == S_WR);
        m_wen_nxt  = (state_nxt == S_WR);
        m_addr_nxt = m_addr;
        m_din_nxt  = m_din;
        if (state_nxt == S_RD)
            m_addr_nxt = (state == S_IDLE) ? src_addr : src_ptr + ADDR_W'(1);
        if (state_nxt == S_WR) begin
            m_addr_nxt = dst_ptr;
            m_din_nxt  = m_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
        end else begin
            if (accept) begin
                src_ptr   <= src_addr;
                dst_ptr   <= dst_addr;
                remaining <= len;
            end
            if (state == S_RD)
                wait_cnt <= WCW'(RD_LAT);
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt - WCW'(1);
            if (state == S_WR) begin
                src_ptr   <= src_ptr + ADDR_W'(1);
                dst_ptr   <= dst_ptr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            checksum <= '0;
        else if (accept)
            checksum <= '0;
        else if (state == S_WR)
            checksum <= checksum ^ m_din;
    end
`endif

endmodule
